// File: rtl/opl3_host_reg_writer_if.sv
// Purpose : host-side OPL3 write bus (address/data port strobes plus status).
// Latency : none, plain wires between host and writer.
// Backpr. : host must hold off while host_ready=0, otherwise the strobe is lost and overrun sets.
// Signals : host_wr/host_addr/host_din/overrun_clr driven by the host;
//           host_ready/overrun/busy driven by the writer.
interface opl3_host_reg_writer_if;
  logic       host_wr;
  logic [1:0] host_addr;
  logic [7:0] host_din;
  logic       host_ready;
  logic       overrun;
  logic       overrun_clr;
  logic       busy;

  modport master (
    output host_wr, host_addr, host_din, overrun_clr,
    input  host_ready, overrun, busy
  );

  modport slave (
    input  host_wr, host_addr, host_din, overrun_clr,
    output host_ready, overrun, busy
  );
endinterface

// File: rtl/opl3_host_reg_writer.sv
// Purpose : queues OPL3 address/data port writes and drains them into a 512-byte register image at chip pacing.
// Latency : data write into an idle, empty writer lands in slv8_reg two cycles after its strobe.
// Backpr. : host_ready = FIFO not full (registered); strobes while not ready are dropped and flagged by sticky overrun.
// Ports   : clk, reset_n (async active-low); host (slave side of opl3_host_reg_writer_if);
//           slv8_reg[511:0] register image indexed by {bank, addr[7:0]}.
module opl3_host_reg_writer #(
  parameter int FIFO_DEPTH       = 16,
  parameter int ADDR_WAIT_CYCLES = 32,
  parameter int DATA_WAIT_CYCLES = 96
) (
  input  logic                 clk,
  input  logic                 reset_n,
  opl3_host_reg_writer_if.slave host,
  output logic [511:0][7:0]    slv8_reg
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int MAXW  = (ADDR_WAIT_CYCLES > DATA_WAIT_CYCLES) ? ADDR_WAIT_CYCLES : DATA_WAIT_CYCLES;
  localparam int WW    = $clog2(MAXW + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_WAIT = 2'd1,
    S_DATA_WAIT = 2'd2
  } state_t;

  // FIFO entry layout: {addr[1], addr[0], din[7:0]}
  logic [9:0]          r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_nxt;
  logic                r_ready;
  logic                r_overrun;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WW-1:0]       r_wait;
  logic [WW-1:0]       w_wait_nxt;
  logic [8:0]          r_latched;
  logic [511:0][7:0]   r_img;

  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_addr_ld;
  logic                w_commit;
  logic [9:0]          w_head;

  assign w_push = host.host_wr & r_ready;
  assign w_drop = host.host_wr & ~r_ready;
  assign w_head = r_mem[r_rd_ptr];

  // ---------------- write queue ----------------
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {host.host_addr, host.host_din};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready   <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      // Pointers are exactly log2(depth) wide, so they wrap on their own.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      // Ready is registered from the next count so the host sees a clean flop.
      r_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
      // A drop in the same cycle as a clear must still leave the flag set.
      if (w_drop)                 r_overrun <= 1'b1;
      else if (host.overrun_clr)  r_overrun <= 1'b0;
    end
  end

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_pop       = 1'b0;
    w_addr_ld   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (!w_head[8]) begin
            w_addr_ld   = 1'b1;
            w_wait_nxt  = WW'(ADDR_WAIT_CYCLES - 1);
            w_state_nxt = S_ADDR_WAIT;
          end else begin
            w_commit    = 1'b1;
            w_wait_nxt  = WW'(DATA_WAIT_CYCLES - 1);
            w_state_nxt = S_DATA_WAIT;
          end
        end
      end
      S_ADDR_WAIT, S_DATA_WAIT: begin
        // Counter is loaded with N-1, so exactly N cycles are spent here.
        if (r_wait == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_nxt = r_wait - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // ---------------- latched address and register image ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latched <= 9'h000;
      for (int i = 0; i < 512; i++) begin
        r_img[i] <= 8'h00;
      end
    end else begin
      // addr[1] selects the bank only on address-port writes.
      if (w_addr_ld) r_latched <= {w_head[9], w_head[7:0]};
      if (w_commit)  r_img[r_latched] <= w_head[7:0];
    end
  end

  assign slv8_reg        = r_img;
  assign host.host_ready = r_ready;
  assign host.overrun    = r_overrun;
  assign host.busy       = (r_count != '0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_opl3_host_reg_writer.sv
// Purpose : directed self-checking bench for opl3_host_reg_writer.
// Latency : inputs driven 1 time unit after the rising edge; outputs checked there too.
// Backpr. : exercises FIFO full, dropped strobes and overrun clearing.
module tb_opl3_host_reg_writer;

  localparam int FIFO_DEPTH = 16;
  localparam int AW         = 32;
  localparam int DW         = 96;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [511:0][7:0] img;
  int                n_vec  = 0;
  int                n_fail = 0;

  opl3_host_reg_writer_if bus ();

  opl3_host_reg_writer #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .ADDR_WAIT_CYCLES(AW),
    .DATA_WAIT_CYCLES(DW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .host    (bus),
    .slv8_reg(img)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] a, input logic [7:0] d);
    bus.host_wr   = 1'b1;
    bus.host_addr = a;
    bus.host_din  = d;
    tick();
    bus.host_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  function automatic int nz_except(input int a, input int b);
    int c;
    c = 0;
    for (int i = 0; i < 512; i++) begin
      if (i != a && i != b && img[i] != 8'h00) c++;
    end
    return c;
  endfunction

  initial begin
    int acc;
    int k;
    int c11, c22, c33;

    reset_n         = 1'b0;
    bus.host_wr     = 1'b0;
    bus.host_addr   = 2'b00;
    bus.host_din    = 8'h00;
    bus.overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   {31'd0, bus.host_ready}, 32'd1);
    chk("rst_overrun", {31'd0, bus.overrun},    32'd0);
    chk("rst_busy",    {31'd0, bus.busy},       32'd0);
    chk("rst_image",   nz_except(-1, -1),       32'd0);
    reset_n = 1'b1;
    tick();

    // Data write with no prior address write goes to byte 0, two cycles after strobe.
    strobe(2'b01, 8'h7F);
    chk("t6_not_yet", img[0], 8'h00);
    chk("t6_busy",    {31'd0, bus.busy}, 32'd1);
    tick();
    chk("t6_commit",  img[0], 8'h7F);
    wait_idle(200, "t6_idle");

    // Address 0x0A0 then data 0x44, back to back.
    strobe(2'b00, 8'hA0);
    strobe(2'b01, 8'h44);
    repeat (AW) tick();
    chk("t1_before", img[9'h0A0], 8'h00);
    tick();
    chk("t1_commit", img[9'h0A0], 8'h44);
    repeat (DW - 1) tick();
    chk("t1_busy_hold", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("t1_busy_drop", {31'd0, bus.busy}, 32'd0);
    chk("t1_others",    nz_except(0, 9'h0A0), 32'd0);
    chk("t1_byte0",     img[0], 8'h7F);

    // Bank 1 via addr[1]; data write with addr[1]=1 must not change the bank.
    strobe(2'b10, 8'h05);
    strobe(2'b11, 8'h01);
    wait_idle(300, "t2_idle");
    chk("t2_bank1", img[9'h105], 8'h01);
    chk("t2_bank0", img[9'h005], 8'h00);
    chk("t2_keepA0", img[9'h0A0], 8'h44);

    // One address, three data writes: latched address reused, spacing DW+1.
    strobe(2'b00, 8'hB0);
    strobe(2'b01, 8'h11);
    strobe(2'b01, 8'h22);
    strobe(2'b01, 8'h33);
    c11 = -1; c22 = -1; c33 = -1;
    for (int t = 1; t < 600; t++) begin
      tick();
      if (c11 < 0 && img[9'h0B0] == 8'h11) c11 = t;
      if (c22 < 0 && img[9'h0B0] == 8'h22) c22 = t;
      if (c33 < 0 && img[9'h0B0] == 8'h33) c33 = t;
      if (!bus.busy) break;
    end
    chk("t4_first_lat", c11, AW - 1);
    chk("t4_space_12",  c22 - c11, DW + 1);
    chk("t4_space_23",  c33 - c22, DW + 1);
    chk("t4_final",     img[9'h0B0], 8'h33);
    chk("t4_no_incr",   img[9'h0B1], 8'h00);
    chk("t4_idle",      {31'd0, bus.busy}, 32'd0);

    // Fill the FIFO while the FSM sits in an address wait.
    strobe(2'b00, 8'hC0);
    tick();
    acc = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      acc += int'(bus.host_ready);
      strobe(2'b01, 8'(8'h80 + i));
    end
    chk("t3_accepted",  acc, FIFO_DEPTH);
    chk("t3_full",      {31'd0, bus.host_ready}, 32'd0);
    chk("t3_no_ovr",    {31'd0, bus.overrun},    32'd0);
    strobe(2'b01, 8'hEE);
    chk("t3_overrun",   {31'd0, bus.overrun},    32'd1);
    bus.host_wr     = 1'b1;
    bus.host_din    = 8'hEF;
    bus.overrun_clr = 1'b1;
    tick();
    bus.host_wr     = 1'b0;
    bus.overrun_clr = 1'b0;
    chk("t3_drop_wins", {31'd0, bus.overrun},    32'd1);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    chk("t3_cleared",   {31'd0, bus.overrun},    32'd0);
    wait_idle(2500, "t3_idle");
    chk("t3_last_data", img[9'h0C0], 8'h8F);

    // Reset during a data wait with five entries still queued.
    strobe(2'b00, 8'hD0);
    strobe(2'b01, 8'h55);
    for (int i = 0; i < 5; i++) strobe(2'b01, 8'(8'h60 + i));
    k = 0;
    while (img[9'h0D0] != 8'h55 && k < 100) begin
      tick();
      k++;
    end
    chk("t5_commit", img[9'h0D0], 8'h55);
    chk("t5_waiting", {31'd0, bus.busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_busy",  {31'd0, bus.busy},       32'd0);
    chk("t5_ready", {31'd0, bus.host_ready}, 32'd1);
    chk("t5_image", nz_except(-1, -1),       32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (300) tick();
    chk("t5_no_commit", nz_except(-1, -1),   32'd0);
    chk("t5_idle",      {31'd0, bus.busy},   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
